// File: rtl/ts_rx_analyzer_mlane.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ts_rx_analyzer_mlane
//  Purpose  : Multi-lane TS1/TS2 receive analyzer. Each lane's received
//             ordered set is compared against the expectation armed for the
//             current LTSSM substate. Consecutive matches are counted per lane
//             and substate completion is flagged once every participating
//             lane reached the target and the TX side reports enough TS sent.
//  Ports    : clk, rst (async, active high)
//             ts_info/ts_update/ts_stop  - arm / abort control from the LTSSM
//             speed, cfg_*               - expected TS description
//             to_tsa_ts_sent_enough      - TX side completion
//             ts_valid/ts                - per-lane received TS
//             lane_cnt/lane_done         - per-lane progress
//             rx_enough/done/done_pulse  - completion indications
//             cur_info/cap_ctrl          - latched state info, lane-0 control
//  Revision : 1.0 - initial release
// ============================================================================
module ts_rx_analyzer_mlane #(
   parameter int LANES = 4,
   parameter int TS_W  = 128,
   parameter int CNT_W = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             ts_info,
   input  logic                   ts_update,
   input  logic                   ts_stop,
   input  logic                   speed,
   input  logic                   cfg_type,
   input  logic [7:0]             cfg_link,
   input  logic [1:0]             cfg_link_mode,
   input  logic                   cfg_lane_chk,
   input  logic [CNT_W-1:0]       cfg_target,
   input  logic [LANES-1:0]       cfg_lane_mask,
   input  logic                   to_tsa_ts_sent_enough,
   input  logic [LANES-1:0]       ts_valid,
   input  logic [LANES*TS_W-1:0]  ts,
   output logic [LANES*CNT_W-1:0] lane_cnt,
   output logic [LANES-1:0]       lane_done,
   output logic                   rx_enough,
   output logic                   done,
   output logic                   done_pulse,
   output logic [7:0]             cur_info,
   output logic [7:0]             cap_ctrl
);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [7:0]       PAD_SYM  = 8'hF7;
   localparam logic [7:0]       COM_SYM  = 8'hBC;
   localparam logic [7:0]       TS1_ID8  = 8'h4A;
   localparam logic [7:0]       TS2_ID8  = 8'h45;
   localparam logic [7:0]       TS1_ID13 = 8'h1E;
   localparam logic [7:0]       TS2_ID13 = 8'h2D;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [7:0]         info_q, info_d;
   logic               type_q, type_d;
   logic [7:0]         link_q, link_d;
   logic [1:0]         link_mode_q, link_mode_d;
   logic               lane_chk_q, lane_chk_d;
   logic [CNT_W-1:0]   target_q, target_d;
   logic [LANES-1:0]   mask_q, mask_d;
   logic               sent_q, sent_d;
   logic               rx_q, rx_d;
   logic [CNT_W-1:0]   cnt_q [LANES];
   logic [CNT_W-1:0]   cnt_d [LANES];
   logic [LANES-1:0]   lane_done_q, lane_done_d;
   logic [7:0]         cap_q, cap_d;

   logic [LANES-1:0]   match;
   logic [CNT_W-1:0]   tgt_eff;
   logic               clear;
   logic               arm_load;
   logic               count_en;

   // A programmed target of zero behaves as one.
   assign tgt_eff = (target_q == '0) ? CNT_ONE : target_q;

   // ---------------------------------------------------------------------
   // Per-lane match decode (latched cfg, live speed)
   // ---------------------------------------------------------------------
   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] b0, b1, b2, b6;
      logic       id_ok, link_ok, lane_ok;
      logic       unused_ts;

      assign b0 = ts[gi*TS_W +  0 +: 8];
      assign b1 = ts[gi*TS_W +  8 +: 8];
      assign b2 = ts[gi*TS_W + 16 +: 8];
      assign b6 = ts[gi*TS_W + 48 +: 8];
      // Remaining symbols carry nothing this block checks.
      assign unused_ts = ^ts[gi*TS_W +: TS_W];

      always_comb begin
         id_ok = 1'b0;
         if (speed) begin
            id_ok = (b0 == (type_q ? TS2_ID13 : TS1_ID13));
         end else begin
            id_ok = (b0 == COM_SYM) && (b6 == (type_q ? TS2_ID8 : TS1_ID8));
         end
         link_ok = 1'b1;
         case (link_mode_q)
            2'd1:    link_ok = (b1 == link_q);
            2'd2:    link_ok = (b1 == PAD_SYM);
            default: link_ok = 1'b1;
         endcase
         lane_ok = ~lane_chk_q | (b2 == 8'(gi));
      end

      assign match[gi] = id_ok & link_ok & lane_ok;
      assign lane_cnt[gi*CNT_W +: CNT_W] = cnt_q[gi];
   end

   // ---------------------------------------------------------------------
   // FSM next state
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      if (ts_stop) begin
         state_d = ST_IDLE;
      end else if (ts_update) begin
         state_d = ST_ARMED;
      end else if ((state_q == ST_ARMED) && done) begin
         state_d = ST_DONE;
      end
   end

   // ---------------------------------------------------------------------
   // Datapath next state
   // ---------------------------------------------------------------------
   always_comb begin
      // Stop beats update; either one discards TS of the same cycle.
      clear       = ts_stop | ts_update;
      arm_load    = ts_update & ~ts_stop;
      count_en    = (state_q == ST_ARMED) & ~clear;

      info_d      = info_q;
      type_d      = type_q;
      link_d      = link_q;
      link_mode_d = link_mode_q;
      lane_chk_d  = lane_chk_q;
      target_d    = target_q;
      mask_d      = mask_q;
      if (arm_load) begin
         info_d      = ts_info;
         type_d      = cfg_type;
         link_d      = cfg_link;
         link_mode_d = cfg_link_mode;
         lane_chk_d  = cfg_lane_chk;
         target_d    = cfg_target;
         mask_d      = cfg_lane_mask;
      end

      sent_d = clear ? 1'b0
                     : (sent_q | ((state_q == ST_ARMED) & to_tsa_ts_sent_enough));

      // An empty mask must never complete.
      rx_d = ~clear & (mask_q != '0) & (&(lane_done_q | ~mask_q));

      lane_done_d = '0;
      for (int i = 0; i < LANES; i++) begin
         cnt_d[i] = cnt_q[i];
         if (clear) begin
            cnt_d[i] = '0;
         end else if (count_en && ts_valid[i]) begin
            if (match[i]) begin
               cnt_d[i] = (cnt_q[i] < tgt_eff) ? (cnt_q[i] + CNT_ONE) : tgt_eff;
            end else begin
               cnt_d[i] = '0;
            end
         end
         lane_done_d[i] = (cnt_d[i] == tgt_eff);
      end

      cap_d = cap_q;
      if (count_en && ts_valid[0] && match[0]) begin
         cap_d = ts[40 +: 8];
      end
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         info_q      <= '0;
         type_q      <= 1'b0;
         link_q      <= '0;
         link_mode_q <= '0;
         lane_chk_q  <= 1'b0;
         target_q    <= '0;
         mask_q      <= '0;
         sent_q      <= 1'b0;
         rx_q        <= 1'b0;
         lane_done_q <= '0;
         cap_q       <= '0;
         for (int i = 0; i < LANES; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         info_q      <= info_d;
         type_q      <= type_d;
         link_q      <= link_d;
         link_mode_q <= link_mode_d;
         lane_chk_q  <= lane_chk_d;
         target_q    <= target_d;
         mask_q      <= mask_d;
         sent_q      <= sent_d;
         rx_q        <= rx_d;
         lane_done_q <= lane_done_d;
         cap_q       <= cap_d;
         for (int i = 0; i < LANES; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign lane_done  = lane_done_q;
   assign rx_enough  = rx_q;
   assign done       = rx_q & sent_q;
   // Leaving ARMED on the first done cycle limits this to one pulse per arm.
   assign done_pulse = (state_q == ST_ARMED) & done;
   assign cur_info   = info_q;
   assign cap_ctrl   = cap_q;

endmodule
`default_nettype wire

// File: tb/tb_ts_rx_analyzer_mlane.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ts_rx_analyzer_mlane
//  Purpose  : Self-checking bench for ts_rx_analyzer_mlane. A cycle model
//             predicts all outputs; expectations are queued when stimulus is
//             driven and compared after the clock edge. A vector table covers
//             the match decode, hand sequences cover multi-cycle corners.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ts_rx_analyzer_mlane;
   localparam int LANES = 4;
   localparam int TS_W  = 128;
   localparam int CNT_W = 5;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [7:0]             ts_info;
   logic                   ts_update, ts_stop, speed, cfg_type;
   logic [7:0]             cfg_link;
   logic [1:0]             cfg_link_mode;
   logic                   cfg_lane_chk;
   logic [CNT_W-1:0]       cfg_target;
   logic [LANES-1:0]       cfg_lane_mask;
   logic                   to_tsa_ts_sent_enough;
   logic [LANES-1:0]       ts_valid;
   logic [LANES*TS_W-1:0]  ts;
   logic [LANES*CNT_W-1:0] lane_cnt;
   logic [LANES-1:0]       lane_done;
   logic                   rx_enough, done, done_pulse;
   logic [7:0]             cur_info, cap_ctrl;

   logic [TS_W-1:0]        ts_l [LANES];

   always #5 clk = ~clk;

   always_comb begin
      ts = '0;
      for (int i = 0; i < LANES; i++) ts[i*TS_W +: TS_W] = ts_l[i];
   end

   ts_rx_analyzer_mlane #(.LANES(LANES), .TS_W(TS_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .ts_info(ts_info), .ts_update(ts_update),
      .ts_stop(ts_stop), .speed(speed), .cfg_type(cfg_type),
      .cfg_link(cfg_link), .cfg_link_mode(cfg_link_mode),
      .cfg_lane_chk(cfg_lane_chk), .cfg_target(cfg_target),
      .cfg_lane_mask(cfg_lane_mask),
      .to_tsa_ts_sent_enough(to_tsa_ts_sent_enough), .ts_valid(ts_valid),
      .ts(ts), .lane_cnt(lane_cnt), .lane_done(lane_done),
      .rx_enough(rx_enough), .done(done), .done_pulse(done_pulse),
      .cur_info(cur_info), .cap_ctrl(cap_ctrl)
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------
   int         m_state;            // 0 idle, 1 armed, 2 done
   int         m_cnt [LANES];
   bit [3:0]   m_ld;
   bit         m_rx, m_sent, m_type, m_chk;
   bit [7:0]   m_info, m_cap, m_link;
   bit [1:0]   m_mode;
   int         m_tgt_raw;
   bit [3:0]   m_mask;

   typedef struct {
      logic [LANES*CNT_W-1:0] cnt;
      logic [LANES-1:0]       ld;
      logic                   rx, dn, dp;
      logic [7:0]             info, cap;
   } exp_t;
   exp_t sb [$];

   task automatic m_reset();
      m_state = 0; m_ld = '0; m_rx = 0; m_sent = 0; m_type = 0; m_chk = 0;
      m_info = 0; m_cap = 0; m_link = 0; m_mode = 0; m_tgt_raw = 0; m_mask = 0;
      for (int i = 0; i < LANES; i++) m_cnt[i] = 0;
   endtask

   function automatic bit m_match(int lane, logic [TS_W-1:0] t);
      bit id, lk;
      if (speed == 1'b0) id = (t[7:0] == 8'hBC) && (t[55:48] == (m_type ? 8'h45 : 8'h4A));
      else               id = (t[7:0] == (m_type ? 8'h2D : 8'h1E));
      if (m_mode == 2'd1)      lk = (t[15:8] == m_link);
      else if (m_mode == 2'd2) lk = (t[15:8] == 8'hF7);
      else                     lk = 1'b1;
      return id && lk && (!m_chk || (t[23:16] == 8'(lane)));
   endfunction

   task automatic model_step();
      int  tgt, ncnt [LANES], nstate;
      bit  clr, allok, nrx, nsent;
      bit [3:0] nld;
      bit [7:0] ncap;
      tgt = (m_tgt_raw == 0) ? 1 : m_tgt_raw;
      clr = ts_stop || ts_update;
      allok = 1;
      for (int i = 0; i < LANES; i++) if (m_mask[i] && !m_ld[i]) allok = 0;
      nrx   = !clr && (m_mask != 0) && allok;
      nsent = clr ? 0 : (m_sent || (m_state == 1 && to_tsa_ts_sent_enough));
      for (int i = 0; i < LANES; i++) begin
         ncnt[i] = m_cnt[i];
         if (clr) ncnt[i] = 0;
         else if (m_state == 1 && ts_valid[i])
            ncnt[i] = m_match(i, ts_l[i]) ? ((m_cnt[i] < tgt) ? m_cnt[i] + 1 : tgt) : 0;
         nld[i] = (ncnt[i] == tgt);
      end
      ncap = m_cap;
      if (!clr && m_state == 1 && ts_valid[0] && m_match(0, ts_l[0])) ncap = ts_l[0][47:40];
      if (ts_stop) nstate = 0;
      else if (ts_update) nstate = 1;
      else if (m_state == 1 && m_rx && m_sent) nstate = 2;
      else nstate = m_state;
      if (ts_update && !ts_stop) begin
         m_info = ts_info; m_type = cfg_type; m_link = cfg_link; m_mode = cfg_link_mode;
         m_chk = cfg_lane_chk; m_tgt_raw = int'(cfg_target); m_mask = cfg_lane_mask;
      end
      for (int i = 0; i < LANES; i++) m_cnt[i] = ncnt[i];
      m_ld = nld; m_rx = nrx; m_sent = nsent; m_cap = ncap; m_state = nstate;
   endtask

   function automatic exp_t m_out();
      exp_t e;
      for (int i = 0; i < LANES; i++) e.cnt[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
      e.ld = m_ld; e.rx = m_rx; e.dn = m_rx && m_sent;
      e.dp = (m_state == 1) && m_rx && m_sent;
      e.info = m_info; e.cap = m_cap;
      return e;
   endfunction

   int pulses = 0;

   task automatic tick();
      exp_t e;
      model_step();
      sb.push_back(m_out());
      @(posedge clk); #1;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 1, 0);
      end else begin
         e = sb.pop_front();
         chk("lane_cnt",   lane_cnt,   e.cnt);
         chk("lane_done",  lane_done,  e.ld);
         chk("rx_enough",  rx_enough,  e.rx);
         chk("done",       done,       e.dn);
         chk("done_pulse", done_pulse, e.dp);
         chk("cur_info",   cur_info,   e.info);
         chk("cap_ctrl",   cap_ctrl,   e.cap);
      end
      if (done_pulse) pulses++;
   endtask

   function automatic logic [TS_W-1:0] raw(logic [7:0] b0, b1, b2, b5, b6);
      logic [TS_W-1:0] t;
      t = '0;
      t[7:0] = b0; t[15:8] = b1; t[23:16] = b2; t[47:40] = b5; t[55:48] = b6;
      t[127:120] = 8'h4A;   // filler symbol, never inspected
      return t;
   endfunction

   // Well-formed TS for the given speed/type.
   function automatic logic [TS_W-1:0] mk(bit sp, bit ty, logic [7:0] lnk, logic [7:0] ln, logic [7:0] ctl);
      if (sp) return raw(ty ? 8'h2D : 8'h1E, lnk, ln, ctl, 8'h00);
      else    return raw(8'hBC, lnk, ln, ctl, ty ? 8'h45 : 8'h4A);
   endfunction

   task automatic all_lanes(bit ty, logic [7:0] lnk, logic [7:0] ctl);
      for (int i = 0; i < LANES; i++) ts_l[i] = mk(speed, ty, lnk, 8'(i), ctl);
      ts_valid = '1;
   endtask

   task automatic arm(bit sp, bit ty, logic [1:0] mode, bit lchk, logic [CNT_W-1:0] tgt,
                      logic [3:0] msk, bit sent);
      speed = sp; cfg_type = ty; cfg_link_mode = mode; cfg_lane_chk = lchk;
      cfg_target = tgt; cfg_lane_mask = msk; to_tsa_ts_sent_enough = sent;
      ts_update = 1'b1;
      tick();
      ts_update = 1'b0;
   endtask

   typedef struct {
      bit sp, ty; logic [1:0] mode; bit lchk; logic [7:0] lnk;
      logic [7:0] b0, b1, b2, b6; logic [3:0] exp;
   } vec_t;
   vec_t vt [14];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; ts_info = 8'h00; ts_update = 0; ts_stop = 0; speed = 0;
      cfg_type = 0; cfg_link = 8'h00; cfg_link_mode = 0; cfg_lane_chk = 0;
      cfg_target = '0; cfg_lane_mask = '0; to_tsa_ts_sent_enough = 0; ts_valid = '0;
      for (int i = 0; i < LANES; i++) ts_l[i] = '0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_lane_cnt", lane_cnt, 0);
      chk("rst_lane_done", lane_done, 0);
      chk("rst_done", {rx_enough, done, done_pulse}, 0);
      chk("rst_info_cap", {cur_info, cap_ctrl}, 0);
      rst = 1'b0;

      // ---------------- match decode table (target 0 acts as 1) -------
      //          sp ty mode chk link  b0     b1     b2     b6     exp
      vt[0]  = '{1, 0, 0, 0, 8'h00, 8'h1E, 8'h00, 8'h00, 8'h00, 4'hF};
      vt[1]  = '{1, 0, 0, 0, 8'h00, 8'h2D, 8'h00, 8'h00, 8'h00, 4'h0};
      vt[2]  = '{1, 1, 0, 0, 8'h00, 8'h2D, 8'h00, 8'h00, 8'h00, 4'hF};
      vt[3]  = '{0, 0, 0, 0, 8'h00, 8'hBC, 8'h00, 8'h00, 8'h4A, 4'hF};
      vt[4]  = '{0, 0, 0, 0, 8'h00, 8'hBC, 8'h00, 8'h00, 8'h45, 4'h0};
      vt[5]  = '{0, 1, 0, 0, 8'h00, 8'hBC, 8'h00, 8'h00, 8'h45, 4'hF};
      vt[6]  = '{0, 0, 0, 0, 8'h00, 8'h1E, 8'h00, 8'h00, 8'h4A, 4'h0};
      vt[7]  = '{1, 0, 1, 0, 8'h05, 8'h1E, 8'h05, 8'h00, 8'h00, 4'hF};
      vt[8]  = '{1, 0, 1, 0, 8'h05, 8'h1E, 8'h06, 8'h00, 8'h00, 4'h0};
      vt[9]  = '{1, 0, 2, 0, 8'h00, 8'h1E, 8'hF7, 8'h00, 8'h00, 4'hF};
      vt[10] = '{1, 0, 2, 0, 8'h00, 8'h1E, 8'h01, 8'h00, 8'h00, 4'h0};
      vt[11] = '{1, 0, 3, 0, 8'h00, 8'h1E, 8'h01, 8'h00, 8'h00, 4'hF};
      vt[12] = '{1, 0, 0, 1, 8'h00, 8'h1E, 8'h00, 8'h02, 8'h00, 4'h4};
      vt[13] = '{1, 0, 0, 0, 8'h00, 8'h1E, 8'h00, 8'h00, 8'h99, 4'hF};
      for (int v = 0; v < 14; v++) begin
         cfg_link = vt[v].lnk; ts_info = 8'(8'h10 + v);
         arm(vt[v].sp, vt[v].ty, vt[v].mode, vt[v].lchk, '0, 4'hF, 1'b0);
         for (int i = 0; i < LANES; i++)
            ts_l[i] = raw(vt[v].b0, vt[v].b1, vt[v].b2, 8'(8'h60 + v), vt[v].b6);
         ts_valid = '1;
         tick();
         chk($sformatf("vec%0d_lane_done", v), lane_done, vt[v].exp);
         ts_valid = '0;
      end
      cfg_link = 8'h00;

      // ---------------- A: 8 TS1 at gen3, all lanes, sent high ---------
      ts_info = 8'h21;
      speed = 1; all_lanes(0, 8'h00, 8'hEE);      // valid on arm cycle is discarded
      arm(1, 0, 0, 0, 5'd8, 4'hF, 1'b1);
      pulses = 0;
      for (int k = 0; k < 8; k++) begin all_lanes(0, 8'h00, 8'(8'h10 + k)); tick(); end
      chk("A_cnt8", lane_cnt, {4{5'd8}});
      chk("A_ld", lane_done, 4'hF);
      chk("A_rx_not_yet", rx_enough, 0);
      ts_valid = '0; tick();
      chk("A_done", {rx_enough, done, done_pulse}, 3'b111);
      chk("A_cap", cap_ctrl, 8'h17);
      repeat (3) tick();
      chk("A_one_pulse", pulses, 1);

      // ---------------- B: lane 2 breaks the run after 5 -----------------
      arm(1, 0, 0, 0, 5'd8, 4'hF, 1'b1);
      for (int k = 0; k < 5; k++) begin all_lanes(0, 8'h00, 8'h30); tick(); end
      all_lanes(0, 8'h00, 8'h31); ts_l[2] = mk(1, 1, 8'h00, 8'd2, 8'h31); tick();
      chk("B_lane2_cnt", lane_cnt[2*CNT_W +: CNT_W], 0);
      chk("B_lane2_ld", lane_done[2], 0);
      chk("B_lane0_cnt", lane_cnt[0 +: CNT_W], 6);
      for (int k = 0; k < 7; k++) begin all_lanes(0, 8'h00, 8'h32); tick(); end
      chk("B_not_done", done, 0);
      tick();
      chk("B_lane2_cnt8", lane_cnt[2*CNT_W +: CNT_W], 8);
      ts_valid = '0; tick();
      chk("B_done", {done, done_pulse}, 2'b11);

      // ---------------- C: gen1, link must be PAD ------------------------
      speed = 0;
      arm(0, 0, 2, 0, 5'd2, 4'hF, 1'b1);
      for (int k = 0; k < 3; k++) begin
         all_lanes(0, 8'hF7, 8'h40); ts_l[1] = mk(0, 0, 8'h01, 8'd1, 8'h40); tick();
      end
      chk("C_lane1_zero", lane_cnt[1*CNT_W +: CNT_W], 0);
      chk("C_lane0_two", lane_cnt[0 +: CNT_W], 2);
      for (int k = 0; k < 2; k++) begin all_lanes(0, 8'hF7, 8'h41); tick(); end
      chk("C_lane1_two", lane_cnt[1*CNT_W +: CNT_W], 2);
      ts_valid = '0; tick();

      // ---------------- D: lane check, lane 3 masked off -----------------
      speed = 1;
      arm(1, 0, 0, 1, 5'd3, 4'h7, 1'b1);
      for (int k = 0; k < 3; k++) begin
         all_lanes(0, 8'h00, 8'h50); ts_l[3] = mk(1, 0, 8'h00, 8'd0, 8'h50); tick();
      end
      ts_valid = '0; tick();
      chk("D_done", done, 1);
      chk("D_lane3", lane_cnt[3*CNT_W +: CNT_W], 0);

      // ---------------- E: late sent_enough -----------------------------
      arm(1, 0, 0, 0, 5'd2, 4'hF, 1'b0);
      for (int k = 0; k < 2; k++) begin all_lanes(0, 8'h00, 8'h60); tick(); end
      ts_valid = '0;
      repeat (10) tick();
      chk("E_rx_wait", {rx_enough, done}, 2'b10);
      to_tsa_ts_sent_enough = 1; tick();
      chk("E_done_late", {done, done_pulse}, 2'b11);
      to_tsa_ts_sent_enough = 0; tick();
      chk("E_done_sticky", {done, done_pulse}, 2'b10);

      // ---------------- G: empty mask never completes --------------------
      arm(1, 0, 0, 0, 5'd0, 4'h0, 1'b1);
      for (int k = 0; k < 3; k++) begin all_lanes(0, 8'h00, 8'h70); tick(); end
      ts_valid = '0; tick();
      chk("G_mask0", {rx_enough, done}, 2'b00);

      // ---------------- F: async reset mid-ARMED, stop+update ------------
      ts_info = 8'h5A;
      arm(1, 0, 0, 0, 5'd8, 4'hF, 1'b1);
      for (int k = 0; k < 4; k++) begin all_lanes(0, 8'h00, 8'h80); tick(); end
      chk("F_cnt4", lane_cnt, {4{5'd4}});
      #2 rst = 1'b1;
      #1;
      chk("F_async_cnt", lane_cnt, 0);
      chk("F_async_flags", {lane_done, rx_enough, done, done_pulse}, 0);
      chk("F_async_info_cap", {cur_info, cap_ctrl}, 0);
      m_reset();
      ts_valid = '0;
      #1 rst = 1'b0;
      arm(1, 0, 0, 0, 5'd1, 4'hF, 1'b1);
      ts_stop = 1; ts_update = 1; all_lanes(0, 8'h00, 8'h90); tick();
      ts_stop = 0; ts_update = 0;
      tick();
      chk("F_stop_wins_idle", lane_cnt, 0);
      chk("F_stop_no_done", done, 0);
      ts_valid = '0; tick();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/ts_rx_analyzer_mlane.md
Name: ts_rx_analyzer_mlane

Overview:
Multi-lane, parametrised successor to the single-stream TS analyzer in the LTSSM sim. It checks every lane's received TS1/TS2 ordered sets against the expectation programmed for the current LTSSM substate and counts consecutive matches per lane. When all enabled lanes reach the target and the transmit side reports enough TS sent, it flags substate completion to the LTSSM controller. Supports 8b/10b (speed=0) and 128b/130b (speed=1) identification and selectable link/lane-number checks.

Parameters:
LANES, 4, number of lanes analysed in parallel
TS_W, 128, width of one TS (16 symbols; byte k = ts[8k+7:8k])
CNT_W, 5, per-lane consecutive-match counter width

Ports:
clk  in  1  1GHz system clock
rst  in  1  asynchronous active-high reset
ts_info  in  8  LTSSM state[7:4] / substate[3:0]; latched on ts_update
ts_update  in  1  arm pulse: latch ts_info + cfg_*, clear counters, enter ARMED
ts_stop  in  1  abort pulse: return to IDLE, clear counters
speed  in  1  0 = 8b/10b TS format, 1 = 128b/130b
cfg_type  in  1  expected TS: 0 = TS1, 1 = TS2
cfg_link  in  8  expected link number
cfg_link_mode  in  2  0 = ignore, 1 = equal cfg_link, 2 = must be PAD 8'hF7, 3 = ignore
cfg_lane_chk  in  1  1 = byte2 must equal lane index
cfg_target  in  CNT_W  consecutive matches required (0 treated as 1)
cfg_lane_mask  in  LANES  lanes participating in completion
to_tsa_ts_sent_enough  in  1  TX side has sent its required count
ts_valid  in  LANES  per-lane TS strobe
ts  in  LANES*TS_W  per-lane TS, lane i at [i*TS_W +: TS_W]
lane_cnt  out  LANES*CNT_W  per-lane consecutive-match count
lane_done  out  LANES  lane reached target
rx_enough  out  1  all masked lanes done
done  out  1  rx_enough & latched sent_enough
done_pulse  out  1  one-cycle pulse on done rising
cur_info  out  8  latched ts_info
cap_ctrl  out  8  byte5 (training control) of lane 0's last matching TS

Behaviour:
- Reset: all outputs 0, FSM IDLE, latched cfg 0.
- FSM IDLE -> ARMED on ts_update; ARMED -> DONE when done rises; ARMED/DONE -> IDLE on ts_stop; ts_update in any state re-arms (counters cleared, ARMED).
- ts_stop and ts_update in the same cycle: stop wins. ts_update with ts_valid in the same cycle: TS ignored, counters cleared.
- Match (lane i): speed=0: byte0==8'hBC and byte6 == (TS1 ? 8'h4A : 8'h45); speed=1: byte0 == (TS1 ? 8'h1E : 8'h2D); plus the link check per cfg_link_mode and, if cfg_lane_chk, byte2 == i. Uses latched cfg and live speed.
- In ARMED only: valid+match -> lane_cnt increments, saturating at target; valid+mismatch -> lane_cnt = 0 (consecutive rule) and lane_done clears. ts_valid low -> hold. IDLE/DONE ignore ts_valid; counts hold in DONE.
- lane_done[i] = (lane_cnt[i] == effective target), registered; lane_cnt and lane_done visible the cycle after ts_valid (N+1).
- sent_enough is latched sticky in ARMED and cleared on ts_update/ts_stop.
- rx_enough = &(lane_done | ~mask) with mask != 0, registered at N+2. Mask 0 -> never asserts.
- done = rx_enough & sent_enough, same cycle as rx_enough (or the cycle after a late sent_enough). done_pulse fires once per arm.
- cap_ctrl updates on every lane-0 match in ARMED; cleared only by reset.

Test Plan:
- speed=1, TS1, mask=4'hF, target=8; 8 matching TS on all lanes each cycle, sent_enough high -> lane_cnt=8 at N+1 of the 8th; rx_enough/done at N+2; one done_pulse.
- Lane 2 receives a TS2 after 5 matches -> lane_cnt[2]=0 and lane_done[2]=0; needs 8 more; done is delayed accordingly.
- speed=0, cfg_link_mode=2, byte1=8'h01 on lane 1 -> lane 1 never counts; with byte1=8'hF7 it counts.
- cfg_lane_chk=1, lane 3 carrying lane number 0 -> lane 3 stays 0; mask=4'h7 -> done still asserts.
- Targets met but sent_enough asserted 10 cycles later -> done and done_pulse rise on the cycle after sent_enough.
- rst asserted mid-ARMED with counts=4 -> all outputs 0 immediately (async); ts_stop+ts_update in the same cycle -> IDLE.
